instruction_decode_stage: RTL and testbench
===========================================

INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

Interface
REQ-001 Parameter IPC, default 4: instruction lanes per group; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]; lane 0 is oldest.
REQ-002 Parameter DATA_WIDTH, default 32: instruction and immediate width.
REQ-003 Parameter RF_WIDTH, default 5: register index width.
REQ-004 Parameter OPCODE_WIDTH, default 7; EXEC_WIDTH, default 4.
REQ-005 One clock; reset is synchronous and active-high (ports clk, rst).
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 flush  in  1  discard all buffered groups, synchronous.
REQ-009 DEC_data  in  IPC*DATA_WIDTH  fetched instruction group.
REQ-010 DEC_dataValid  in  1  group present; DEC_laneValid  in  IPC  per-lane presence mask.
REQ-011 DEC_ready  out  1  stage accepts a group this cycle; registered, not a combinational function of out_ready.
REQ-012 out_valid  out  1; out_ready  in  1  downstream accept.
REQ-013 Per-lane outputs, packed like DEC_data: laneValid (1), opcode (OPCODE_WIDTH), rs1/rs2/rd (RF_WIDTH), func3 (3), func7 (7), imm (DATA_WIDTH), executionID (EXEC_WIDTH), type (3: 0 NONE, 1 R, 2 I, 3 LOAD, 4 STORE, 5 BRANCH, 6 LUI), illegal (1).

Function
REQ-014 Transfer in when DEC_dataValid && DEC_ready; transfer out when out_valid && out_ready.
REQ-015 Storage is a 2-entry skid buffer (main + skid register) holding fully decoded groups; decode is combinational ahead of the main register; latency = 1 cycle from accepted input to out_valid.
REQ-016 States: EMPTY (out_valid=0, DEC_ready=1), ONE (out_valid=1, DEC_ready=1), FULL (out_valid=1, DEC_ready=0).
REQ-017 EMPTY: in -> ONE. ONE: in&&!out -> FULL; out&&!in -> EMPTY; in&&out -> ONE with new group. FULL: out -> ONE, skid group moves to main.
REQ-018 Throughput: one group per cycle sustained while out_ready=1; no bubble on out_ready 0->1.
REQ-019 Output group SHALL remain stable while out_valid && !out_ready.
REQ-020 Opcode 0110011 -> R: rs1,rs2,rd,func3,func7 from fields; imm=0.
REQ-021 Opcode 0010011 -> I; 0000011 -> LOAD: rs1,rd,func3; imm=sext(inst[31:20]); rs2=0, func7=0.
REQ-022 Opcode 0100011 -> STORE: rs1,rs2,func3; imm=sext({inst[31:25],inst[11:7]}); rd=0.
REQ-023 Opcode 1100011 -> BRANCH: rs1,rs2,func3; imm=sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}); rd=0.
REQ-024 Opcode 0110111 -> LUI: rd; imm={inst[31:12],12'b0}; rs1=rs2=0.
REQ-025 executionID codes: AND 0, OR 1, SRA 2, SRL 3, XOR 4, SLTU 5, SLT 6, SLL 7, SUB 8, ADD 9, NOP 15.
REQ-026 R: func3 000 -> ADD (func7[5]=0) / SUB (=1); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL/SRA by func7[5]; 110 OR; 111 AND.
REQ-027 I: as R except 000 always ADD; shifts decoded identically.
REQ-028 LOAD, STORE, LUI -> ADD; BRANCH -> SUB.
REQ-029 Any other opcode on a valid lane: type NONE, executionID NOP, illegal=1, all fields 0.
REQ-030 Lanes with DEC_laneValid=0: laneValid=0, type NONE, NOP, illegal=0, all fields 0; opcode always = inst[6:0] for valid lanes, 0 otherwise.
REQ-031 Each lane's executionID SHALL be written only in its own EXEC_WIDTH slice.
REQ-032 flush: next cycle state EMPTY, out_valid=0, DEC_ready=1; an input offered in the flush cycle is dropped; flush has priority over in/out.

Reset
REQ-033 While rst=1 at a clock edge: state EMPTY, out_valid=0, DEC_ready=1, all lane outputs 0, executionID all NOP; rst has priority over flush and any handshake, including mid-stall with FULL.

Verification
REQ-034 Lane0=0x002081B3 (ADD x3,x1,x2), laneValid=0001, out_ready=1 -> next cycle lane0 type R, rs1=1, rs2=2, rd=3, executionID=9; lanes 1-3 laneValid=0, NOP.
REQ-035 Lanes=0x407302B3 SUB, 0xFFF00093 ADDI x1,x0,-1, 0x0020A423 SW x2,8(x1), 0xFFFFFFFF -> IDs 8,9,9,15; lane1 imm=0xFFFFFFFF; lane2 imm=8, rd=0; lane3 illegal=1.
REQ-036 out_ready=0 for 3 cycles, groups A,B,C offered -> A,B accepted, DEC_ready=0 from cycle 3, C held; out_ready=1 -> A,B,C emitted in order, none lost or duplicated.
REQ-037 Stream 100 random groups, out_ready random 50% -> output order/content matches scoreboard; stable under stall.
REQ-038 FULL state, assert flush -> next cycle out_valid=0, DEC_ready=1; subsequent group emitted after 1 cycle.
REQ-039 rst asserted in FULL with out_ready=0 -> next cycle all outputs 0, executionID 0xFFFF (IPC=4), DEC_ready=1.

Source files
------------

// File: rtl/instruction_decode_stage.sv
// Instruction decode stage: combinational per-lane decode feeding a
// two-entry (main + skid) buffer of fully decoded instruction groups.
module instruction_decode_stage #(
   parameter int unsigned IPC          = 4,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned RF_WIDTH     = 5,
   parameter int unsigned OPCODE_WIDTH = 7,
   parameter int unsigned EXEC_WIDTH   = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic [IPC*DATA_WIDTH-1:0]    DEC_data,
   input  logic                         DEC_dataValid,
   input  logic [IPC-1:0]               DEC_laneValid,
   output logic                         DEC_ready,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [IPC-1:0]               laneValid,
   output logic [IPC*OPCODE_WIDTH-1:0]  opcode,
   output logic [IPC*RF_WIDTH-1:0]      rs1,
   output logic [IPC*RF_WIDTH-1:0]      rs2,
   output logic [IPC*RF_WIDTH-1:0]      rd,
   output logic [IPC*3-1:0]             func3,
   output logic [IPC*7-1:0]             func7,
   output logic [IPC*DATA_WIDTH-1:0]    imm,
   output logic [IPC*EXEC_WIDTH-1:0]    executionID,
   output logic [IPC*3-1:0]             inst_type,
   output logic [IPC-1:0]               illegal
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [2:0] T_NONE   = 3'd0;
   localparam logic [2:0] T_R      = 3'd1;
   localparam logic [2:0] T_I      = 3'd2;
   localparam logic [2:0] T_LOAD   = 3'd3;
   localparam logic [2:0] T_STORE  = 3'd4;
   localparam logic [2:0] T_BRANCH = 3'd5;
   localparam logic [2:0] T_LUI    = 3'd6;

   localparam logic [EXEC_WIDTH-1:0] EX_AND  = EXEC_WIDTH'(0);
   localparam logic [EXEC_WIDTH-1:0] EX_OR   = EXEC_WIDTH'(1);
   localparam logic [EXEC_WIDTH-1:0] EX_SRA  = EXEC_WIDTH'(2);
   localparam logic [EXEC_WIDTH-1:0] EX_SRL  = EXEC_WIDTH'(3);
   localparam logic [EXEC_WIDTH-1:0] EX_XOR  = EXEC_WIDTH'(4);
   localparam logic [EXEC_WIDTH-1:0] EX_SLTU = EXEC_WIDTH'(5);
   localparam logic [EXEC_WIDTH-1:0] EX_SLT  = EXEC_WIDTH'(6);
   localparam logic [EXEC_WIDTH-1:0] EX_SLL  = EXEC_WIDTH'(7);
   localparam logic [EXEC_WIDTH-1:0] EX_SUB  = EXEC_WIDTH'(8);
   localparam logic [EXEC_WIDTH-1:0] EX_ADD  = EXEC_WIDTH'(9);
   localparam logic [EXEC_WIDTH-1:0] EX_NOP  = EXEC_WIDTH'(15);

   typedef struct packed {
      logic                    valid;
      logic [OPCODE_WIDTH-1:0] opcode;
      logic [RF_WIDTH-1:0]     rs1;
      logic [RF_WIDTH-1:0]     rs2;
      logic [RF_WIDTH-1:0]     rd;
      logic [2:0]              func3;
      logic [6:0]              func7;
      logic [DATA_WIDTH-1:0]   imm;
      logic [EXEC_WIDTH-1:0]   exec_id;
      logic [2:0]              kind;
      logic                    illegal;
   } lane_t;

   typedef lane_t [IPC-1:0] group_t;

   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

   // ALU operation for R/I arithmetic; only R uses func7[5] to pick SUB
   function automatic logic [EXEC_WIDTH-1:0] alu_id(input logic [2:0] f3,
                                                     input logic       alt,
                                                     input logic       is_r);
      logic [EXEC_WIDTH-1:0] id;
      id = EX_NOP;
      case (f3)
         3'b000:  id = (is_r && alt) ? EX_SUB : EX_ADD;
         3'b001:  id = EX_SLL;
         3'b010:  id = EX_SLT;
         3'b011:  id = EX_SLTU;
         3'b100:  id = EX_XOR;
         3'b101:  id = alt ? EX_SRA : EX_SRL;
         3'b110:  id = EX_OR;
         default: id = EX_AND;
      endcase
      return id;
   endfunction

   function automatic lane_t idle_lane();
      lane_t l;
      l         = '0;
      l.exec_id = EX_NOP;
      return l;
   endfunction

   function automatic group_t idle_group();
      group_t g;
      for (int i = 0; i < int'(IPC); i++) g[i] = idle_lane();
      return g;
   endfunction

   function automatic lane_t decode_lane(input logic [DATA_WIDTH-1:0] inst,
                                         input logic                  valid);
      lane_t l;
      l = idle_lane();
      if (valid) begin
         l.valid  = 1'b1;
         l.opcode = OPCODE_WIDTH'(inst[6:0]);
         case (inst[6:0])
            OP_R: begin
               l.kind    = T_R;
               l.rs1     = RF_WIDTH'(inst[19:15]);
               l.rs2     = RF_WIDTH'(inst[24:20]);
               l.rd      = RF_WIDTH'(inst[11:7]);
               l.func3   = inst[14:12];
               l.func7   = inst[31:25];
               l.exec_id = alu_id(inst[14:12], inst[30], 1'b1);
            end
            OP_I, OP_LOAD: begin
               l.kind    = (inst[6:0] == OP_I) ? T_I : T_LOAD;
               l.rs1     = RF_WIDTH'(inst[19:15]);
               l.rd      = RF_WIDTH'(inst[11:7]);
               l.func3   = inst[14:12];
               l.imm     = DATA_WIDTH'($signed(inst[31:20]));
               l.exec_id = (inst[6:0] == OP_I) ? alu_id(inst[14:12], inst[30], 1'b0)
                                               : EX_ADD;
            end
            OP_STORE: begin
               l.kind    = T_STORE;
               l.rs1     = RF_WIDTH'(inst[19:15]);
               l.rs2     = RF_WIDTH'(inst[24:20]);
               l.func3   = inst[14:12];
               l.imm     = DATA_WIDTH'($signed({inst[31:25], inst[11:7]}));
               l.exec_id = EX_ADD;
            end
            OP_BRANCH: begin
               l.kind    = T_BRANCH;
               l.rs1     = RF_WIDTH'(inst[19:15]);
               l.rs2     = RF_WIDTH'(inst[24:20]);
               l.func3   = inst[14:12];
               l.imm     = DATA_WIDTH'($signed({inst[31], inst[7], inst[30:25],
                                                inst[11:8], 1'b0}));
               l.exec_id = EX_SUB;
            end
            OP_LUI: begin
               l.kind    = T_LUI;
               l.rd      = RF_WIDTH'(inst[11:7]);
               l.imm     = DATA_WIDTH'({inst[31:12], 12'b0});
               l.exec_id = EX_ADD;
            end
            default: l.illegal = 1'b1;
         endcase
      end
      return l;
   endfunction

   state_t state;
   group_t main_q;
   group_t skid_q;
   group_t dec_c;
   logic   in_fire;
   logic   out_fire;

   always_comb begin
      dec_c = idle_group();
      for (int i = 0; i < int'(IPC); i++)
         dec_c[i] = decode_lane(DEC_data[i*DATA_WIDTH +: DATA_WIDTH], DEC_laneValid[i]);
   end

   assign in_fire  = DEC_dataValid && DEC_ready;
   assign out_fire = out_valid && out_ready;

   // Skid-buffer control; out_valid/DEC_ready are registered alongside state
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_EMPTY;
         out_valid <= 1'b0;
         DEC_ready <= 1'b1;
         main_q    <= idle_group();
         skid_q    <= idle_group();
      end else if (flush) begin
         state     <= S_EMPTY;
         out_valid <= 1'b0;
         DEC_ready <= 1'b1;
         main_q    <= idle_group();
      end else begin
         unique case (state)
            S_EMPTY: begin
               if (in_fire) begin
                  main_q    <= dec_c;
                  state     <= S_ONE;
                  out_valid <= 1'b1;
               end
            end
            S_ONE: begin
               if (in_fire && out_fire) begin
                  main_q <= dec_c;
               end else if (in_fire) begin
                  skid_q    <= dec_c;
                  state     <= S_FULL;
                  DEC_ready <= 1'b0;
               end else if (out_fire) begin
                  state     <= S_EMPTY;
                  out_valid <= 1'b0;
               end
            end
            S_FULL: begin
               if (out_fire) begin
                  main_q    <= skid_q;
                  state     <= S_ONE;
                  DEC_ready <= 1'b1;
               end
            end
            default: begin
               state     <= S_EMPTY;
               out_valid <= 1'b0;
               DEC_ready <= 1'b1;
            end
         endcase
      end
   end

   for (genvar i = 0; i < int'(IPC); i++) begin : g_lane_out
      assign laneValid[i]                              = main_q[i].valid;
      assign opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH]    = main_q[i].opcode;
      assign rs1[i*RF_WIDTH +: RF_WIDTH]               = main_q[i].rs1;
      assign rs2[i*RF_WIDTH +: RF_WIDTH]               = main_q[i].rs2;
      assign rd[i*RF_WIDTH +: RF_WIDTH]                = main_q[i].rd;
      assign func3[i*3 +: 3]                           = main_q[i].func3;
      assign func7[i*7 +: 7]                           = main_q[i].func7;
      assign imm[i*DATA_WIDTH +: DATA_WIDTH]           = main_q[i].imm;
      assign executionID[i*EXEC_WIDTH +: EXEC_WIDTH]   = main_q[i].exec_id;
      assign inst_type[i*3 +: 3]                       = main_q[i].kind;
      assign illegal[i]                                = main_q[i].illegal;
   end

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Bench for instruction_decode_stage: table of hand-decoded instructions,
// a scoreboard monitor, and directed stall / flush / reset sequences.
module tb_instruction_decode_stage;

   localparam int unsigned IPC = 4;
   localparam int unsigned DW  = 32;
   localparam int unsigned RFW = 5;
   localparam int unsigned OPW = 7;
   localparam int unsigned EW  = 4;
   localparam int unsigned LW  = 1 + OPW + 3*RFW + 3 + 7 + DW + EW + 3 + 1;
   localparam int unsigned GW  = IPC * LW;
   localparam int          NV  = 21;

   typedef logic [LW-1:0] lane_v;
   typedef logic [GW-1:0] group_v;

   typedef struct {
      logic [31:0] inst;
      logic [2:0]  typ;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [3:0]  eid;
      logic        ill;
   } vec_t;

   logic                 clk;
   logic                 rst;
   logic                 flush;
   logic [IPC*DW-1:0]    DEC_data;
   logic                 DEC_dataValid;
   logic [IPC-1:0]       DEC_laneValid;
   logic                 DEC_ready;
   logic                 out_valid;
   logic                 out_ready;
   logic [IPC-1:0]       laneValid;
   logic [IPC*OPW-1:0]   opcode;
   logic [IPC*RFW-1:0]   rs1;
   logic [IPC*RFW-1:0]   rs2;
   logic [IPC*RFW-1:0]   rd;
   logic [IPC*3-1:0]     func3;
   logic [IPC*7-1:0]     func7;
   logic [IPC*DW-1:0]    imm;
   logic [IPC*EW-1:0]    executionID;
   logic [IPC*3-1:0]     inst_type;
   logic [IPC-1:0]       illegal;

   vec_t   tbl [NV];
   group_v drv_exp;
   group_v q [$];
   logic   acc_flag;
   int     pops;
   int     total;
   int     bad;

   instruction_decode_stage #(
      .IPC(IPC), .DATA_WIDTH(DW), .RF_WIDTH(RFW), .OPCODE_WIDTH(OPW), .EXEC_WIDTH(EW)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .DEC_data(DEC_data), .DEC_dataValid(DEC_dataValid), .DEC_laneValid(DEC_laneValid),
      .DEC_ready(DEC_ready), .out_valid(out_valid), .out_ready(out_ready),
      .laneValid(laneValid), .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd),
      .func3(func3), .func7(func7), .imm(imm), .executionID(executionID),
      .inst_type(inst_type), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input group_v act, input group_v exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic lane_v exp_lane(input int k);
      lane_v v;
      v = {1'b1, tbl[k].inst[6:0], tbl[k].rs1, tbl[k].rs2, tbl[k].rd, tbl[k].f3,
           tbl[k].f7, tbl[k].imm, tbl[k].eid, tbl[k].typ, tbl[k].ill};
      return v;
   endfunction

   function automatic lane_v idle_lane();
      lane_v v;
      v = {1'b0, 7'd0, 15'd0, 3'd0, 7'd0, 32'd0, 4'hF, 3'd0, 1'b0};
      return v;
   endfunction

   function automatic group_v idle_group();
      group_v g;
      for (int l = 0; l < int'(IPC); l++) g[l*LW +: LW] = idle_lane();
      return g;
   endfunction

   function automatic lane_v act_lane(input int l);
      lane_v v;
      v = {laneValid[l], opcode[l*OPW +: OPW], rs1[l*RFW +: RFW], rs2[l*RFW +: RFW],
           rd[l*RFW +: RFW], func3[l*3 +: 3], func7[l*7 +: 7], imm[l*DW +: DW],
           executionID[l*EW +: EW], inst_type[l*3 +: 3], illegal[l]};
      return v;
   endfunction

   function automatic group_v act_group();
      group_v g;
      for (int l = 0; l < int'(IPC); l++) g[l*LW +: LW] = act_lane(l);
      return g;
   endfunction

   // Drive a group built from table entries; masked lanes must decode as idle
   task automatic offer_idx(input int i0, input int i1, input int i2, input int i3,
                            input logic [3:0] lv);
      int ix [4];
      ix = '{i0, i1, i2, i3};
      for (int l = 0; l < int'(IPC); l++) begin
         DEC_data[l*DW +: DW]  = tbl[ix[l]].inst;
         drv_exp[l*LW +: LW]   = lv[l] ? exp_lane(ix[l]) : idle_lane();
      end
      DEC_laneValid = lv;
      DEC_dataValid = 1'b1;
   endtask

   task automatic offer_rand();
      offer_idx(int'($urandom_range(0, NV-1)), int'($urandom_range(0, NV-1)),
                int'($urandom_range(0, NV-1)), int'($urandom_range(0, NV-1)),
                4'($urandom_range(0, 15)));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: one queue entry per buffered group; occupancy gives valid/ready
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         acc_flag = 1'b0;
      end else begin
         chk("mon_valid", GW'(out_valid), GW'(q.size() != 0));
         chk("mon_ready", GW'(DEC_ready), GW'(q.size() < 2));
         if (out_valid && q.size() != 0) chk("mon_data", act_group(), q[0]);
         acc_flag = DEC_dataValid && DEC_ready && !flush;
         if (flush) begin
            q.delete();
         end else begin
            if (out_valid && out_ready && q.size() != 0) begin
               void'(q.pop_front());
               pops++;
            end
            if (acc_flag) q.push_back(drv_exp);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      group_v ga, gb, gc, gd;
      int     p0, sent, cyc;
      logic   c_acc;

      //        inst           typ   rs1   rs2   rd    f3    f7      imm            eid   ill
      tbl[0]  = '{32'h002081B3, 3'd1, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'h00000000, 4'd9,  1'b0};
      tbl[1]  = '{32'h407302B3, 3'd1, 5'd6, 5'd7, 5'd5, 3'd0, 7'h20, 32'h00000000, 4'd8,  1'b0};
      tbl[2]  = '{32'hFFF00093, 3'd2, 5'd0, 5'd0, 5'd1, 3'd0, 7'h00, 32'hFFFFFFFF, 4'd9,  1'b0};
      tbl[3]  = '{32'h0020A423, 3'd4, 5'd1, 5'd2, 5'd0, 3'd2, 7'h00, 32'h00000008, 4'd9,  1'b0};
      tbl[4]  = '{32'hFFFFFFFF, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 4'd15, 1'b1};
      tbl[5]  = '{32'h123452B7, 3'd6, 5'd0, 5'd0, 5'd5, 3'd0, 7'h00, 32'h12345000, 4'd9,  1'b0};
      tbl[6]  = '{32'hFFC12303, 3'd3, 5'd2, 5'd0, 5'd6, 3'd2, 7'h00, 32'hFFFFFFFC, 4'd9,  1'b0};
      tbl[7]  = '{32'h00209863, 3'd5, 5'd1, 5'd2, 5'd0, 3'd1, 7'h00, 32'h00000010, 4'd8,  1'b0};
      tbl[8]  = '{32'hFE000FE3, 3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFE, 4'd8,  1'b0};
      tbl[9]  = '{32'h40315093, 3'd2, 5'd2, 5'd0, 5'd1, 3'd5, 7'h00, 32'h00000403, 4'd2,  1'b0};
      tbl[10] = '{32'h40000013, 3'd2, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000400, 4'd9,  1'b0};
      tbl[11] = '{32'h00209133, 3'd1, 5'd1, 5'd2, 5'd2, 3'd1, 7'h00, 32'h00000000, 4'd7,  1'b0};
      tbl[12] = '{32'h0020A133, 3'd1, 5'd1, 5'd2, 5'd2, 3'd2, 7'h00, 32'h00000000, 4'd6,  1'b0};
      tbl[13] = '{32'h0020B133, 3'd1, 5'd1, 5'd2, 5'd2, 3'd3, 7'h00, 32'h00000000, 4'd5,  1'b0};
      tbl[14] = '{32'h0020C133, 3'd1, 5'd1, 5'd2, 5'd2, 3'd4, 7'h00, 32'h00000000, 4'd4,  1'b0};
      tbl[15] = '{32'h0020D133, 3'd1, 5'd1, 5'd2, 5'd2, 3'd5, 7'h00, 32'h00000000, 4'd3,  1'b0};
      tbl[16] = '{32'h4020D133, 3'd1, 5'd1, 5'd2, 5'd2, 3'd5, 7'h20, 32'h00000000, 4'd2,  1'b0};
      tbl[17] = '{32'h0020E133, 3'd1, 5'd1, 5'd2, 5'd2, 3'd6, 7'h00, 32'h00000000, 4'd1,  1'b0};
      tbl[18] = '{32'h0020F133, 3'd1, 5'd1, 5'd2, 5'd2, 3'd7, 7'h00, 32'h00000000, 4'd0,  1'b0};
      tbl[19] = '{32'h0000006F, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 4'd15, 1'b1};
      tbl[20] = '{32'hFF00F093, 3'd2, 5'd1, 5'd0, 5'd1, 3'd7, 7'h00, 32'hFFFFFFF0, 4'd0,  1'b0};

      total = 0; bad = 0; pops = 0; acc_flag = 1'b0;
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      DEC_data = '0; DEC_dataValid = 1'b0; DEC_laneValid = '0; drv_exp = '0;

      tick(); tick();
      chk("reset_valid", GW'(out_valid), GW'(1'b0));
      chk("reset_ready", GW'(DEC_ready), GW'(1'b1));
      chk("reset_group", act_group(), idle_group());
      rst = 1'b0;
      tick();

      // One instruction per vector, rotated across lanes, other lanes masked garbage
      out_ready = 1'b1;
      for (int k = 0; k < NV; k++) begin
         offer_idx((k % 4 == 0) ? k : 4, (k % 4 == 1) ? k : 4,
                   (k % 4 == 2) ? k : 4, (k % 4 == 3) ? k : 4, 4'(1 << (k % 4)));
         tick();
         chk($sformatf("vec%0d_valid", k), GW'(out_valid), GW'(1'b1));
         chk($sformatf("vec%0d_lane%0d", k, k % 4), GW'(act_lane(k % 4)), GW'(exp_lane(k)));
         chk($sformatf("vec%0d_group", k), act_group(), drv_exp);
      end
      DEC_dataValid = 1'b0;
      tick();

      // Mixed four-lane group
      offer_idx(1, 2, 3, 4, 4'hF);
      tick();
      chk("mix_group", act_group(), drv_exp);
      chk("mix_exec_ids", GW'(executionID), GW'(16'hF998));
      chk("mix_lane1_imm", GW'(imm[63:32]), GW'(32'hFFFFFFFF));
      chk("mix_lane3_illegal", GW'(illegal[3]), GW'(1'b1));
      DEC_dataValid = 1'b0;
      tick(); tick();

      // Stall: A, B accepted, C held until downstream drains
      out_ready = 1'b0; p0 = pops;
      offer_idx(5, 6, 7, 8, 4'hF); ga = drv_exp;
      tick();
      chk("stall_a_ready", GW'(DEC_ready), GW'(1'b1));
      offer_idx(9, 10, 11, 12, 4'b1010);
      tick();
      chk("stall_b_ready", GW'(DEC_ready), GW'(1'b0));
      offer_idx(13, 14, 15, 16, 4'hF);
      tick();
      chk("stall_c_ready", GW'(DEC_ready), GW'(1'b0));
      chk("stall_hold_a0", act_group(), ga);
      tick();
      chk("stall_hold_a1", act_group(), ga);
      out_ready = 1'b1; c_acc = 1'b0;
      for (int n = 0; n < 10 && !c_acc; n++) begin
         tick();
         c_acc = acc_flag;
      end
      chk("stall_c_accepted", GW'(c_acc), GW'(1'b1));
      DEC_dataValid = 1'b0;
      for (int n = 0; n < 10 && out_valid; n++) tick();
      chk("stall_pops", GW'(pops - p0), GW'(3));

      // Flush from FULL drops everything including the offered group
      out_ready = 1'b0;
      offer_idx(17, 18, 19, 20, 4'hF); tick();
      offer_idx(0, 1, 2, 3, 4'hF);     tick();
      chk("flush_pre_ready", GW'(DEC_ready), GW'(1'b0));
      flush = 1'b1;
      offer_idx(5, 5, 5, 5, 4'hF);
      tick();
      flush = 1'b0; DEC_dataValid = 1'b0;
      chk("flush_valid", GW'(out_valid), GW'(1'b0));
      chk("flush_ready", GW'(DEC_ready), GW'(1'b1));
      out_ready = 1'b1;
      offer_idx(6, 9, 20, 7, 4'b0111); gd = drv_exp;
      tick();
      DEC_dataValid = 1'b0;
      chk("flush_next_valid", GW'(out_valid), GW'(1'b1));
      chk("flush_next_group", act_group(), gd);
      tick();

      // Reset in FULL with stalled downstream and a concurrent flush/offer
      out_ready = 1'b0;
      offer_idx(1, 1, 1, 1, 4'hF); gb = drv_exp; tick();
      offer_idx(2, 2, 2, 2, 4'hF); gc = drv_exp; tick();
      chk("rst_pre_ready", GW'(DEC_ready), GW'(1'b0));
      rst = 1'b1; flush = 1'b1;
      offer_idx(3, 3, 3, 3, 4'hF);
      tick();
      chk("rst_valid", GW'(out_valid), GW'(1'b0));
      chk("rst_ready", GW'(DEC_ready), GW'(1'b1));
      chk("rst_group", act_group(), idle_group());
      chk("rst_exec_ids", GW'(executionID), GW'(16'hFFFF));
      rst = 1'b0; flush = 1'b0; DEC_dataValid = 1'b0;
      tick();
      chk("rst_after_valid", GW'(out_valid), GW'(1'b0));

      // Random stream checked by the scoreboard
      sent = 0; cyc = 0;
      offer_rand();
      DEC_dataValid = ($urandom_range(0, 3) != 0);
      while (sent < 100 && cyc < 4000) begin
         out_ready = $urandom_range(0, 1) != 0;
         tick();
         cyc++;
         if (acc_flag) begin
            sent++;
            offer_rand();
         end
         DEC_dataValid = ($urandom_range(0, 3) != 0);
      end
      chk("rand_sent", GW'(sent), GW'(100));
      DEC_dataValid = 1'b0; out_ready = 1'b1;
      for (int n = 0; n < 10 && q.size() != 0; n++) tick();
      chk("rand_drain", GW'(q.size()), GW'(0));
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
